// File: rtl/tick_generator_bank_if.sv
// Configuration and output bundle for the tick generator bank.
// The controller drives the configuration side; the bank returns per-channel tick and wave.
interface tick_generator_bank_if #(
    parameter int CHANNELS = 5,
    parameter int WIDTH    = 32,
    parameter int CH_SEL_W = 3
);
    logic                cfg_we;
    logic [CH_SEL_W-1:0] cfg_ch;
    logic [WIDTH-1:0]    cfg_delay;
    logic                cfg_mode;
    logic                cfg_enable;
    logic                sync;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] wave;

    modport master (
        output cfg_we, cfg_ch, cfg_delay, cfg_mode, cfg_enable, sync,
        input  tick, wave
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_delay, cfg_mode, cfg_enable, sync,
        output tick, wave
    );
endinterface

// File: rtl/tick_generator_bank.sv
// Bank of independent programmable dividers producing registered tick pulses
// and 50%-duty square waves, with per-channel runtime configuration and a global restart.
module tick_generator_bank #(
    parameter int CHANNELS    = 5,
    parameter int WIDTH       = 32,
    parameter int RESET_DELAY = 100,
    parameter int CH_SEL_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_generator_bank_if.slave bus
);

    logic [WIDTH-1:0]    cnt_r   [CHANNELS];
    logic [WIDTH-1:0]    delay_r [CHANNELS];
    logic [CHANNELS-1:0] mode_r;
    logic [CHANNELS-1:0] enable_r;
    logic [CHANNELS-1:0] tick_r;
    logic [CHANNELS-1:0] wave_r;

    logic [CHANNELS-1:0] cfg_hit_s;
    logic [CHANNELS-1:0] active_s;
    logic [CHANNELS-1:0] wrap_s;

    // Per-channel decode of the config write, run condition and wrap event.
    always_comb begin
        cfg_hit_s = {CHANNELS{1'b0}};
        active_s  = {CHANNELS{1'b0}};
        wrap_s    = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            // Out-of-range selects never match any channel, so such writes are dropped.
            cfg_hit_s[i] = bus.cfg_we && (bus.cfg_ch == CH_SEL_W'(i));
            active_s[i]  = enable_r[i] && (delay_r[i] != {WIDTH{1'b0}});
            wrap_s[i]    = active_s[i] && (cnt_r[i] == (delay_r[i] - WIDTH'(1)));
        end
    end

    // Channel state: config registers, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]   <= {WIDTH{1'b0}};
                delay_r[i] <= WIDTH'(RESET_DELAY);
            end
            mode_r   <= {CHANNELS{1'b0}};
            enable_r <= {CHANNELS{1'b1}};
            tick_r   <= {CHANNELS{1'b0}};
            wave_r   <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_hit_s[i]) begin
                    delay_r[i]  <= bus.cfg_delay;
                    mode_r[i]   <= bus.cfg_mode;
                    enable_r[i] <= bus.cfg_enable;
                    cnt_r[i]    <= {WIDTH{1'b0}};
                    tick_r[i]   <= 1'b0;
                    wave_r[i]   <= 1'b0;
                end else if (bus.sync || !active_s[i]) begin
                    // Restart (or park) the channel without touching its config.
                    cnt_r[i]  <= {WIDTH{1'b0}};
                    tick_r[i] <= 1'b0;
                    wave_r[i] <= 1'b0;
                end else begin
                    cnt_r[i]  <= wrap_s[i] ? {WIDTH{1'b0}} : (cnt_r[i] + WIDTH'(1));
                    tick_r[i] <= wrap_s[i];
                    wave_r[i] <= mode_r[i] ? (wave_r[i] ^ wrap_s[i]) : 1'b0;
                end
            end
        end
    end

    assign bus.tick = tick_r;
    assign bus.wave = wave_r;

endmodule

// File: tb/tb_tick_generator_bank.sv
// Directed scoreboard bench: stimulus queues hand-computed (cycle, channel, tick, wave)
// expectations; a negedge monitor compares them against the DUT when their cycle arrives.
module tb_tick_generator_bank;

    localparam int CHANNELS = 5;
    localparam int WIDTH    = 32;
    localparam int CH_SEL_W = 3;

    typedef struct {
        int    cyc;
        int    ch;
        logic  t;
        logic  w;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    tick_generator_bank_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CH_SEL_W(CH_SEL_W)) bus ();

    tick_generator_bank #(
        .CHANNELS(CHANNELS), .WIDTH(WIDTH), .RESET_DELAY(100), .CH_SEL_W(CH_SEL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: check every expectation due this cycle, flag any that were skipped.
    always @(negedge clk) begin
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].cyc == edge_cnt) begin
                checks++;
                if (bus.tick[exp_q[k].ch] !== exp_q[k].t || bus.wave[exp_q[k].ch] !== exp_q[k].w) begin
                    errors++;
                    $display("FAIL %s cyc=%0d ch=%0d got tick=%b wave=%b want tick=%b wave=%b",
                             exp_q[k].name, edge_cnt, exp_q[k].ch, bus.tick[exp_q[k].ch],
                             bus.wave[exp_q[k].ch], exp_q[k].t, exp_q[k].w);
                end
                exp_q.delete(k);
            end else if (exp_q[k].cyc < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL %s missed cyc=%0d ch=%0d", exp_q[k].name, exp_q[k].cyc, exp_q[k].ch);
                exp_q.delete(k);
            end
        end
    end

    task automatic exp_push(input int cyc, input int ch, input logic t, input logic w, input string name);
        exp_t e;
        e.cyc = cyc; e.ch = ch; e.t = t; e.w = w; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int cyc);
        while (edge_cnt < cyc) @(negedge clk);
    endtask

    task automatic cfg_write(input int at, input int ch, input int delay, input logic mode,
                             input logic en, input logic with_sync);
        wait_until(at);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = CH_SEL_W'(ch);
        bus.cfg_delay  = WIDTH'(delay);
        bus.cfg_mode   = mode;
        bus.cfg_enable = en;
        bus.sync       = with_sync;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.sync   = 1'b0;
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_ch = 3'd0; bus.cfg_delay = 32'd0;
        bus.cfg_mode = 1'b0; bus.cfg_enable = 1'b0; bus.sync = 1'b0;

        for (int c = 0; c < CHANNELS; c++) begin
            exp_push(1, c, 1'b0, 1'b0, "reset_state");
            exp_push(2, c, 1'b0, 1'b0, "reset_state");
        end

        // Release at cycle 3: default divisor 100 ticks at 103, 203.
        wait_until(3);
        rst = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            exp_push(102, c, 1'b0, 1'b0, "pre_first_tick");
            exp_push(103, c, 1'b1, 1'b0, "first_tick_d100");
            exp_push(104, c, 1'b0, 1'b0, "tick_one_cycle");
        end
        exp_push(203, 0, 1'b1, 1'b0, "ch0_undisturbed");
        exp_push(203, 4, 1'b1, 1'b0, "ch4_second_tick");

        // ch2 D=4 square from edge 151: ticks 155,159,...; wave toggles on each.
        cfg_write(150, 2, 4, 1'b1, 1'b1, 1'b0);
        exp_push(154, 2, 1'b0, 1'b0, "ch2_before_tick");
        exp_push(155, 2, 1'b1, 1'b1, "ch2_tick_wave_up");
        exp_push(156, 2, 1'b0, 1'b1, "ch2_wave_held");
        exp_push(158, 2, 1'b0, 1'b1, "ch2_wave_held");
        exp_push(159, 2, 1'b1, 1'b0, "ch2_tick_wave_dn");
        exp_push(163, 2, 1'b1, 1'b1, "ch2_tick_wave_up");
        exp_push(203, 2, 1'b1, 1'b1, "ch2_long_run");
        exp_push(207, 2, 1'b1, 1'b0, "ch2_long_run");

        // ch3 disabled mid-count (cnt=57 at edge 160): would have ticked at 203.
        cfg_write(159, 3, 100, 1'b0, 1'b0, 1'b0);
        exp_push(203, 3, 1'b0, 1'b0, "ch3_disabled");

        // ch1 D=1 square: tick constant, wave toggles every cycle.
        cfg_write(160, 1, 1, 1'b1, 1'b1, 1'b0);
        exp_push(161, 1, 1'b0, 1'b0, "ch1_d1_write_clr");
        exp_push(162, 1, 1'b1, 1'b1, "ch1_d1_tick");
        exp_push(163, 1, 1'b1, 1'b0, "ch1_d1_tick");
        exp_push(170, 1, 1'b1, 1'b1, "ch1_d1_tick");

        // ch1 D=0: idle forever.
        cfg_write(170, 1, 0, 1'b1, 1'b1, 1'b0);
        exp_push(171, 1, 1'b0, 1'b0, "ch1_d0_idle");
        exp_push(180, 1, 1'b0, 1'b0, "ch1_d0_idle");
        exp_push(203, 1, 1'b0, 1'b0, "ch1_d0_idle");

        // ch3 re-enabled D=10 at edge 211: ticks 221, 231.
        cfg_write(210, 3, 10, 1'b0, 1'b1, 1'b0);
        exp_push(220, 3, 1'b0, 1'b0, "ch3_reenable_pre");
        exp_push(221, 3, 1'b1, 1'b0, "ch3_reenable_tick");
        exp_push(231, 3, 1'b1, 1'b0, "ch3_reenable_tick");

        // ch0/ch4 D=10 out of phase (ticks 251 vs 256).
        cfg_write(240, 0, 10, 1'b0, 1'b1, 1'b0);
        cfg_write(245, 4, 10, 1'b0, 1'b1, 1'b0);
        exp_push(251, 0, 1'b1, 1'b0, "ch0_d10_tick");
        exp_push(251, 4, 1'b0, 1'b0, "ch4_out_of_phase");
        exp_push(256, 4, 1'b1, 1'b0, "ch4_d10_tick");
        exp_push(256, 0, 1'b0, 1'b0, "ch0_out_of_phase");

        // Sync at edge 271: common phase, ticks at 281, 291, 301.
        wait_until(270);
        bus.sync = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        exp_push(271, 0, 1'b0, 1'b0, "sync_suppress");
        exp_push(276, 4, 1'b0, 1'b0, "sync_old_phase");
        for (int c = 0; c < CHANNELS; c += 4) begin
            exp_push(280, c, 1'b0, 1'b0, "sync_pre");
            exp_push(281, c, 1'b1, 1'b0, "sync_in_phase");
            exp_push(291, c, 1'b1, 1'b0, "sync_in_phase");
            exp_push(301, c, 1'b1, 1'b0, "bad_ch_ignored");
        end

        // Out-of-range channel write must change nothing.
        cfg_write(285, 7, 3, 1'b1, 1'b0, 1'b0);
        exp_push(294, 0, 1'b0, 1'b0, "bad_ch_ignored");

        // Write ch0 D=5 together with sync at edge 306; ch2 rephased (ticks 310,314,318).
        cfg_write(305, 0, 5, 1'b0, 1'b1, 1'b1);
        exp_push(311, 0, 1'b1, 1'b0, "sync_write_ch0");
        exp_push(316, 0, 1'b1, 1'b0, "sync_write_ch0");
        exp_push(311, 4, 1'b0, 1'b0, "sync_write_ch4");
        exp_push(316, 4, 1'b1, 1'b0, "sync_write_ch4");
        exp_push(317, 2, 1'b0, 1'b0, "ch2_wave_low");
        exp_push(318, 2, 1'b1, 1'b1, "ch2_wave_high");

        // Async reset shortly after edge 319, released after edge 320.
        wait_until(318);
        exp_push(319, 2, 1'b0, 1'b0, "async_reset_drop");
        exp_push(322, 2, 1'b0, 1'b0, "post_reset_ch2");
        exp_push(330, 2, 1'b0, 1'b0, "post_reset_ch2");
        for (int c = 0; c < CHANNELS; c++) begin
            exp_push(321, c, 1'b0, 1'b0, "post_reset_quiet");
            exp_push(419, c, 1'b0, 1'b0, "post_reset_pre");
            exp_push(420, c, 1'b1, 1'b0, "post_reset_d100");
            exp_push(421, c, 1'b0, 1'b0, "post_reset_one_cycle");
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait_until(424);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_generator_bank.md
Name: tick_generator_bank

Overview:
Multi-channel programmable tick source. It replaces fixed-divisor generator instances with CHANNELS independent counters whose divisor, mode and enable are set at runtime. Each channel emits a one-clock tick pulse or a 50%-duty square wave. It sits at the top level and feeds timing strobes, such as the 1 s, 100 ms, 10 ms, 1 us and transmitter clocks, to downstream blocks.

Parameters:
CHANNELS, 5, number of independent channels (1..8)
WIDTH, 32, counter/divisor width in bits
RESET_DELAY, 100, divisor loaded into every channel at reset; must be < 2^WIDTH
CH_SEL_W, 3, width of channel select; 2^CH_SEL_W >= CHANNELS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  CH_SEL_W  channel addressed by cfg_we
cfg_delay  input  WIDTH  divisor (period in clk cycles)
cfg_mode  input  1  0 = pulse, 1 = square
cfg_enable  input  1  channel enable
sync  input  1  restart all channel counters together
tick  output  CHANNELS  one-cycle pulse per period, per channel
wave  output  CHANNELS  square output (mode 1), else 0

Behaviour:
- Reset (async assert, sync to clk on release):
  - every channel: delay = RESET_DELAY, mode = 0, enable = 1, cnt = 0
  - tick = 0, wave = 0
  - Default power-up therefore equals a free-running divider.
- Per-channel counter, enabled, delay D >= 1:
  - each edge: cnt <= (cnt == D-1) ? 0 : cnt + 1
  - tick[i] registered: high for exactly one cycle following the edge where cnt wraps D-1 -> 0
  - Period is D cycles.
  - First tick is visible after the D-th rising edge following reset release, sync, or a config write to that channel.
- D = 1: tick[i] constantly high (tick every cycle); in mode 1, wave toggles every cycle.
- D = 0: channel idles. cnt held 0, tick 0, wave 0; treated as disabled.
- Mode 1: wave[i] toggles on each wrap event; period 2*D, duty 50%. tick still pulses.
- Mode 0: wave[i] held 0.
- Disabled (enable = 0): cnt held 0, tick 0, wave 0.
- Config write (cfg_we = 1, cfg_ch < CHANNELS):
  - delay/mode/enable for that channel take the input values on that edge
  - that channel's cnt <= 0, tick <= 0, wave <= 0
  - new period counts from that edge
  - Other channels are unaffected.
- cfg_ch >= CHANNELS: write ignored, no state change.
- Divisor reduced below current cnt: no wrap issue, since a write always restarts cnt at 0.
- sync = 1: all channels cnt <= 0, tick <= 0, wave <= 0; config registers are unchanged. Channels with equal D then tick in phase.
- sync and cfg_we in the same cycle: both apply. Write updates config, all counters clear, and a common phase starts.
- Reset mid-operation: all state returns to reset values immediately (async); no partial tick is emitted after rst deasserts.
- Arithmetic: cnt and delay are unsigned WIDTH bits, compare is exact, and no counter may overflow past D-1.
- Outputs: all registered; no combinational path from inputs to tick/wave.

Test Plan:
- Reset release, no writes, RESET_DELAY = 100 -> each tick[i] high 1 cycle at edges 100, 200, 300; wave all 0.
- Write ch2 D = 4, mode 1 -> tick[2] every 4 cycles; wave[2] toggles each tick (8-cycle period, 4 high / 4 low); ch0 timing undisturbed.
- Write ch1 D = 1, then D = 0 -> tick[1] continuously high; after the second write tick[1] = 0 and wave[1] = 0 permanently.
- Write ch3 enable = 0 mid-count (cnt = 57, D = 100) -> tick[3] stays 0. Re-enable with D = 10 -> first tick 10 cycles after the write.
- Ch0 D = 10, ch4 D = 10 out of phase, pulse sync -> both ticks coincide 10 cycles after sync and thereafter. cfg_ch = 7 write -> no channel changes.
- Assert rst for 1 cycle mid-period with ch2 in mode 1 and wave high -> wave/tick drop immediately; all channels resume D = 100, mode 0.
